// File: rtl/nonce_scheduler.sv
// Nonce search sequencer for a double-SHA256 wrapper: walks nonce_start..nonce_end (inclusive, wrapping) and stops on the first hash <= target.
// Optional hash counter output hashes_done is enabled by defining NONCE_SCHED_HASH_COUNT_EN.
module nonce_scheduler #(
  parameter int unsigned HASH_LATENCY = 136
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [0:255]  midstate_in,
  input  logic [0:511]  block2_in,
  input  logic [0:255]  target,
  input  logic [31:0]   nonce_start,
  input  logic [31:0]   nonce_end,
  input  logic [0:255]  hash_value,
  output logic          hasher_rst,
  output logic [0:255]  midstate_out,
  output logic [0:511]  block2_out,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [31:0]   found_nonce,
  output logic [2:0]    state_dbg_o
`ifdef NONCE_SCHED_HASH_COUNT_EN
  ,
  output logic [31:0]   hashes_done
`endif
);

  // Handshake: start is a one-cycle request honoured only in IDLE; done is a one-cycle completion pulse, after which found/found_nonce hold until the next accepted start.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_FINISH} state_t;

  localparam int CW = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HASH_LATENCY - 1);
  localparam logic [0:511] NONCE_MASK = {96'b0, 32'hFFFF_FFFF, 384'b0};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   nonce_q, nonce_d;
  logic [31:0]   end_q, end_d;
  logic [0:255]  ms_q, ms_d;
  logic [0:511]  tmpl_q, tmpl_d;
  logic [0:255]  tgt_q, tgt_d;
  logic          found_q, found_d;
  logic [31:0]   fn_q, fn_d;
`ifdef NONCE_SCHED_HASH_COUNT_EN
  logic [31:0]   hcnt_q, hcnt_d;
`endif

  assign busy        = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_CHECK);
  assign done        = (state_q == S_FINISH);
  // The wrapper only runs through RUN and must keep its result stable into CHECK.
  assign hasher_rst  = !((state_q == S_RUN) || (state_q == S_CHECK));
  assign found       = found_q;
  assign found_nonce = fn_q;
  assign midstate_out = ms_q;
  assign block2_out  = (tmpl_q & ~NONCE_MASK) | {96'b0, nonce_q, 384'b0};
  assign state_dbg_o = state_q;
`ifdef NONCE_SCHED_HASH_COUNT_EN
  assign hashes_done = hcnt_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nonce_d = nonce_q;
    end_d   = end_q;
    ms_d    = ms_q;
    tmpl_d  = tmpl_q;
    tgt_d   = tgt_q;
    found_d = found_q;
    fn_d    = fn_q;
`ifdef NONCE_SCHED_HASH_COUNT_EN
    hcnt_d  = hcnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          ms_d    = midstate_in;
          tmpl_d  = block2_in;
          tgt_d   = target;
          nonce_d = nonce_start;
          end_d   = nonce_end;
          found_d = 1'b0;
          cnt_d   = '0;
`ifdef NONCE_SCHED_HASH_COUNT_EN
          hcnt_d  = '0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHECK: begin
`ifdef NONCE_SCHED_HASH_COUNT_EN
        if (hcnt_q != 32'hFFFF_FFFF) hcnt_d = hcnt_q + 32'd1;
`endif
        // Index 0 is the MSB on both vectors, so a plain unsigned compare applies.
        if (hash_value <= tgt_q) begin
          found_d = 1'b1;
          fn_d    = nonce_q;
          state_d = S_FINISH;
        end else if (nonce_q == end_q) begin
          state_d = S_FINISH;
        end else begin
          nonce_d = nonce_q + 32'd1;
          state_d = S_LOAD;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort && busy) begin
      state_d = S_IDLE;
      found_d = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nonce_q <= '0;
      end_q   <= '0;
      ms_q    <= '0;
      tmpl_q  <= '0;
      tgt_q   <= '0;
      found_q <= 1'b0;
      fn_q    <= '0;
`ifdef NONCE_SCHED_HASH_COUNT_EN
      hcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nonce_q <= nonce_d;
      end_q   <= end_d;
      ms_q    <= ms_d;
      tmpl_q  <= tmpl_d;
      tgt_q   <= tgt_d;
      found_q <= found_d;
      fn_q    <= fn_d;
`ifdef NONCE_SCHED_HASH_COUNT_EN
      hcnt_q  <= hcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_nonce_scheduler.sv
// Self-checking bench for nonce_scheduler: behavioural hasher, nonce-order scoreboard, latency/result/abort/reset checks.
module tb_nonce_scheduler;
  localparam int unsigned LAT = 4;
  localparam int PER = LAT + 2;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RUN  = 3'd2;

  logic         clk, rst, start, abort;
  logic [0:255] midstate_in, target, hash_value, midstate_out;
  logic [0:511] block2_in, block2_out;
  logic [31:0]  nonce_start, nonce_end, found_nonce;
  logic         hasher_rst, busy, done, found;
  logic [2:0]   state_dbg;
`ifdef NONCE_SCHED_HASH_COUNT_EN
  logic [31:0]  hashes_done;
`endif

  nonce_scheduler #(.HASH_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .midstate_in(midstate_in), .block2_in(block2_in), .target(target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .hash_value(hash_value),
    .hasher_rst(hasher_rst), .midstate_out(midstate_out), .block2_out(block2_out),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .state_dbg_o(state_dbg)
`ifdef NONCE_SCHED_HASH_COUNT_EN
    , .hashes_done(hashes_done)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [31:0]  exp_q[$];
  bit           hit_en = 1'b0;
  logic [31:0]  hit_nonce = '0;
  logic [0:255] cur_tgt = '0;
  logic [0:255] cur_ms = '0;
  logic [0:511] cur_b2 = '0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:255] rand256();
    logic [0:255] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [0:511] rand512();
    logic [0:511] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // behavioural hasher: the chosen nonce hashes exactly to target, all others to target+1
  always_comb begin
    if (hit_en && block2_out[96:127] == hit_nonce) hash_value = cur_tgt;
    else hash_value = cur_tgt + 256'd1;
  end

  // scoreboard: every LOAD cycle must present the next expected nonce and the latched block data
  always @(negedge clk) begin
    if (!rst && busy && hasher_rst) begin
      check_eq("exp_q_nonempty", 512'(exp_q.size() != 0), 512'(1'b1));
      if (exp_q.size() != 0) check_eq("load_nonce", 512'(block2_out[96:127]), 512'(exp_q.pop_front()));
      check_eq("midstate_out", 512'(midstate_out), 512'(cur_ms));
      check_eq("template", 512'({block2_out[0:95], block2_out[128:511]}),
               512'({cur_b2[0:95], cur_b2[128:511]}));
    end
    if (done) done_cnt++;
  end

  // driver: call at a negedge; start is sampled at the next posedge, returns at the following negedge
  task automatic launch(input logic [31:0] ns, input logic [31:0] ne, input bit hen,
                        input logic [31:0] hn, input logic [0:255] tgt);
    hit_en = hen; hit_nonce = hn; cur_tgt = tgt;
    cur_ms = rand256(); cur_b2 = rand512();
    midstate_in = cur_ms; block2_in = cur_b2; target = tgt;
    nonce_start = ns; nonce_end = ne; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    midstate_in = rand256(); block2_in = rand512(); target = rand256();
    nonce_start = $urandom(); nonce_end = $urandom();
  endtask

  task automatic do_search(input logic [31:0] ns, input logic [31:0] ne, input bit hen,
                           input logic [31:0] hn, input logic [0:255] tgt, input bit poke);
    logic [31:0] n;
    int n_exp;
    int edges;
    bit exp_found;
    n = ns; n_exp = 0; exp_found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(n);
      n_exp++;
      if (hen && n == hn) begin exp_found = 1'b1; break; end
      if (n == ne) break;
      n = n + 32'd1;
    end
    launch(ns, ne, hen, hn, tgt);
    check_eq("busy_after_start", 512'(busy), 512'(1'b1));
    check_eq("found_cleared", 512'(found), 512'(1'b0));
`ifdef NONCE_SCHED_HASH_COUNT_EN
    check_eq("hashes_cleared", 512'(hashes_done), 512'(0));
`endif
    edges = 0;
    while (!done && edges < 4000) begin
      if (poke && edges == 3) begin start = 1'b1; nonce_start = 32'hDEAD_0000; end
      else start = 1'b0;
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    check_eq("done_seen", 512'(done), 512'(1'b1));
    check_eq("done_latency", 512'(edges), 512'(n_exp * PER));
    check_eq("found", 512'(found), 512'(exp_found));
    if (exp_found) check_eq("found_nonce", 512'(found_nonce), 512'(hn));
    check_eq("busy_at_done", 512'(busy), 512'(1'b0));
    check_eq("hrst_at_done", 512'(hasher_rst), 512'(1'b1));
    check_eq("exp_q_drained", 512'(exp_q.size()), 512'(0));
`ifdef NONCE_SCHED_HASH_COUNT_EN
    check_eq("hashes_done", 512'(hashes_done), 512'(n_exp));
`endif
    @(negedge clk);
    check_eq("done_one_cycle", 512'(done), 512'(1'b0));
    check_eq("found_held", 512'(found), 512'(exp_found));
    check_eq("idle_after", 512'(state_dbg), 512'(ST_IDLE));
  endtask

  initial begin
    int d0;
    logic [31:0] rs;
    logic [0:255] t;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    midstate_in = '0; block2_in = '0; target = '0; nonce_start = '0; nonce_end = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_state", 512'(state_dbg), 512'(ST_IDLE));
    check_eq("rst_hrst", 512'(hasher_rst), 512'(1'b1));
    check_eq("rst_busy", 512'(busy), 512'(1'b0));
    check_eq("rst_done", 512'(done), 512'(1'b0));
    check_eq("rst_found", 512'(found), 512'(1'b0));
    check_eq("rst_fn", 512'(found_nonce), 512'(0));
    check_eq("rst_ms", 512'(midstate_out), 512'(0));
    check_eq("rst_b2", 512'(block2_out), 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // hit at 0x12 with hash == target; stray start while busy
    t = {32'h0000_0000, 32'h0000_FFFF, rand256()} >> 64;
    do_search(32'h10, 32'h13, 1'b1, 32'h12, t, 1'b1);
    // wrap-around exhaustive search, target 0, nearest miss hash 1
    do_search(32'hFFFF_FFFE, 32'h1, 1'b0, 32'h0, 256'd0, 1'b0);
    // hit on the inclusive last nonce
    t = rand256(); t[0] = 1'b0;
    do_search(32'h100, 32'h102, 1'b1, 32'h102, t, 1'b0);

    // abort in RUN of the second nonce
    d0 = done_cnt;
    exp_q.push_back(32'h20); exp_q.push_back(32'h21);
    launch(32'h20, 32'h30, 1'b0, 32'h0, t);
    repeat (PER + 1) @(negedge clk);
    check_eq("pre_abort_run", 512'(state_dbg), 512'(ST_RUN));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_idle", 512'(state_dbg), 512'(ST_IDLE));
    check_eq("abort_busy", 512'(busy), 512'(1'b0));
    check_eq("abort_hrst", 512'(hasher_rst), 512'(1'b1));
    check_eq("abort_done", 512'(done), 512'(1'b0));
    check_eq("abort_found", 512'(found), 512'(1'b0));
    check_eq("abort_no_done", 512'(done_cnt), 512'(d0));
    check_eq("abort_exp_q", 512'(exp_q.size()), 512'(0));
    // single-nonce searches, the first started right after the abort
    do_search(32'h5, 32'h5, 1'b0, 32'h0, t, 1'b0);
    do_search(32'h7, 32'h7, 1'b1, 32'h7, t, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_eq("start_abort_idle", 512'(state_dbg), 512'(ST_IDLE));
    check_eq("start_abort_busy", 512'(busy), 512'(1'b0));

    // rst mid-RUN
    d0 = done_cnt;
    exp_q.push_back(32'h40);
    launch(32'h40, 32'h50, 1'b0, 32'h0, t);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_state", 512'(state_dbg), 512'(ST_IDLE));
    check_eq("mid_rst_busy", 512'(busy), 512'(1'b0));
    check_eq("mid_rst_hrst", 512'(hasher_rst), 512'(1'b1));
    check_eq("mid_rst_fn", 512'(found_nonce), 512'(0));
    check_eq("mid_rst_ms", 512'(midstate_out), 512'(0));
    check_eq("mid_rst_b2", 512'(block2_out), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", 512'(busy), 512'(1'b0));
    check_eq("mid_rst_no_done", 512'(done_cnt), 512'(d0));
    check_eq("mid_rst_exp_q", 512'(exp_q.size()), 512'(0));

    // random short ranges
    for (int k = 0; k < 4; k++) begin
      rs = $urandom();
      t = rand256(); t[0] = 1'b0;
      do_search(rs, rs + 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                rs + 32'($urandom_range(0, 3)), t, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
